cw_capture_ctrl: RTL and testbench
==================================

Name: cw_capture_ctrl

Overview:
- Parametrised trigger-and-capture engine for the on-chip debug watcher.
- Samples a WIDTH-bit probe bus into a circular sample RAM of 2**ADDR_W entries.
- Qualifies the trigger using mask/value compare, edge or change modes, plus an occurrence counter.
- Retains a configurable pre-trigger window and reports trigger and start addresses to the JTAG status register.
- Successor to the fixed-width capture control: adds configurable width, depth, pre-trigger window, trigger modes, occurrence count, sample enable, force trigger and abort.

Parameters:
- WIDTH, 16, probe bus width (1..512).
- ADDR_W, 10, sample RAM address width; DEPTH = 2**ADDR_W.
- TCNT_W, 8, trigger occurrence counter width.

Ports:
- trig_clk  in  1  sample/trigger clock; all logic is in this domain.
- jrstn  in  1  asynchronous active-low reset.
- din  in  WIDTH  probe data.
- sample_en  in  1  sample qualifier; a sample is taken only in cycles where this is high.
- arm  in  1  single-cycle start pulse; latches the configuration.
- abort  in  1  single-cycle stop pulse.
- force_trig  in  1  manual trigger pulse.
- trig_mode  in  2  00 level, 01 rising edge of match, 10 any change, 11 manual only.
- trig_value  in  WIDTH  compare value.
- trig_mask  in  WIDTH  1 = bit participates in the compare.
- trig_count  in  TCNT_W  fire on the Nth qualifying event; 0 is treated as 1.
- pre_len  in  ADDR_W+1  number of pre-trigger samples.
- wt_ce  out  1  RAM chip enable.
- wt_en  out  1  RAM write enable.
- wt_addr  out  ADDR_W  RAM write address.
- wt_data  out  WIDTH  RAM write data.
- state  out  3  0 IDLE, 1 PRE_FILL, 2 ARMED, 3 POST, 4 DONE.
- trig_addr  out  ADDR_W  address of the trigger sample.
- start_addr  out  ADDR_W  address of the oldest retained sample.
- done  out  1  capture complete.

Behaviour:
- Reset: all outputs and internal registers are 0; state is IDLE.
- Configuration:
  - Configuration inputs are sampled only on an accepted arm.
  - pre_len values above DEPTH-1 are clamped to DEPTH-1.
  - An arm in IDLE or DONE is accepted; an arm in any other state is ignored.
  - When abort and arm are asserted in the same cycle, abort wins.
- Write path:
  - A sample taken in cycle n appears in cycle n+1 as wt_en=1, wt_ce=1, wt_data=din(n), wt_addr=current pointer.
  - The pointer increments after each write and wraps from DEPTH-1 to 0.
  - The pointer resets to 0 on an accepted arm.
  - In IDLE and DONE, wt_en and wt_ce are 0.
- Match: match = ((din ^ trig_value) & trig_mask) == 0.
- Qualifying event, evaluated only on sampled cycles:
  - Mode 00: match.
  - Mode 01: match && !match_prev.
  - Mode 10: ((din ^ din_prev) & trig_mask) != 0.
  - Mode 11: never.
  - din_prev and match_prev hold the previous sampled value. They are cleared on arm, so the first sample in modes 01 and 10 compares against 0.
- Trigger:
  - The trigger fires on the trig_count-th qualifying event, or on force_trig.
  - force_trig requires a sampled cycle.
- FSM:
  - IDLE -> PRE_FILL on an accepted arm; goes directly to ARMED if the clamped pre_len is 0.
  - PRE_FILL: writes samples; events are not counted and force_trig is ignored. Moves to ARMED after pre_len writes.
  - ARMED: writes circularly and counts events. When the trigger fires, the trigger sample is written, trig_addr is set to its address, start_addr = trig_addr - pre_len (mod DEPTH), and the FSM moves to POST.
  - POST: writes DEPTH-1-pre_len further samples, then moves to DONE. If that count is 0, the FSM goes from ARMED directly to DONE.
  - DONE: done=1; holds until an accepted arm or abort.
  - Abort in any state returns to IDLE on the next edge. wt_en is 0 from that edge on; trig_addr and start_addr keep their values; done=0.
- Completed capture: exactly DEPTH words written from start_addr up to trig_addr+post, contiguous modulo DEPTH. Samples taken in ARMED before the trigger may be overwritten.
- The occurrence counter saturates; it never wraps within a capture.

Test Plan:
1. ADDR_W=4, WIDTH=8, din=sample index 0,1,2,..., sample_en=1, pre_len=4, mode 00, value 0xA5, mask 0xFF, count 1, arm -> trigger on sample 0xA5; trig_addr=5, start_addr=1; last write is sample 0xB0 at addr 0; 177 wt_en pulses; done=1.
2. Mode 01, mask 0x01, value 0x01, din counting, count 3 -> trigger on the third odd sample (0x05) once ARMED; samples before PRE_FILL completes are not counted.
3. pre_len=20 with ADDR_W=4 -> clamped to 15; trigger sample 0x20 at addr 0; PRE_FILL lasts exactly 15 writes; no POST writes; start_addr=1; done is asserted the cycle after the trigger write.
4. Abort 3 cycles into POST -> state=IDLE next edge; wt_en=0; done=0; trig_addr retained; a following arm restarts at addr 0.
5. sample_en toggling 1,0,1,0, mode 10, mask 0xFF, din changing every cycle -> writes only on sampled cycles; change detected against the previous sampled value, not the previous cycle.
6. Mode 11; force_trig pulsed in PRE_FILL (ignored), then again in ARMED with sample_en=1 -> trigger on the second pulse only; arm pulsed during POST -> ignored.

Source files
------------

// File: rtl/cw_capture_ctrl.sv
// Trigger-and-capture engine for the debug watcher: samples a probe bus into a
// circular RAM, qualifies a trigger and reports trigger/start addresses.
module cw_capture_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TCNT_W = 8
) (
  input  logic              trig_clk,
  input  logic              jrstn,
  input  logic [WIDTH-1:0]  din,
  input  logic              sample_en,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [1:0]        trig_mode,
  input  logic [WIDTH-1:0]  trig_value,
  input  logic [WIDTH-1:0]  trig_mask,
  input  logic [TCNT_W-1:0] trig_count,
  input  logic [ADDR_W:0]   pre_len,
  output logic              wt_ce,
  output logic              wt_en,
  output logic [ADDR_W-1:0] wt_addr,
  output logic [WIDTH-1:0]  wt_data,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE_FILL = 3'd1,
    S_ARMED    = 3'd2,
    S_POST     = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] PRE_MAX = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                wt_en_q, wt_en_d;
  logic [ADDR_W-1:0]   wt_addr_q, wt_addr_d;
  logic [WIDTH-1:0]    wt_data_q, wt_data_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic                done_q, done_d;
  logic [WIDTH-1:0]    din_prev_q, din_prev_d;
  logic                match_prev_q, match_prev_d;
  logic [TCNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [WIDTH-1:0]    value_q, value_d;
  logic [WIDTH-1:0]    mask_q, mask_d;
  logic [TCNT_W-1:0]   tcount_q, tcount_d;
  logic [ADDR_W-1:0]   pre_q, pre_d;

  logic                arm_ok, sampling, match, evt, fire;
  logic [ADDR_W-1:0]   pre_clamped;
  logic [TCNT_W-1:0]   target;
  logic [TCNT_W:0]     cnt_inc;

  always_comb begin
    pre_clamped = (pre_len > {1'b0, PRE_MAX}) ? PRE_MAX : pre_len[ADDR_W-1:0];
    arm_ok   = arm && !abort && (state_q == S_IDLE || state_q == S_DONE);
    sampling = sample_en && (state_q == S_PRE_FILL || state_q == S_ARMED || state_q == S_POST);
    match    = ((din ^ value_q) & mask_q) == '0;
    evt      = 1'b0;
    case (mode_q)
      2'b00:   evt = match;
      2'b01:   evt = match && !match_prev_q;
      2'b10:   evt = ((din ^ din_prev_q) & mask_q) != '0;
      default: evt = 1'b0;
    endcase
    target  = (tcount_q == '0) ? TCNT_W'(1) : tcount_q;
    cnt_inc = {1'b0, cnt_q} + (TCNT_W+1)'(1);
    fire    = force_trig || (evt && (cnt_inc >= {1'b0, target}));

    state_d      = state_q;
    ptr_d        = ptr_q;
    wt_en_d      = 1'b0;
    wt_addr_d    = wt_addr_q;
    wt_data_d    = wt_data_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    done_d       = done_q;
    din_prev_d   = din_prev_q;
    match_prev_d = match_prev_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    value_d      = value_q;
    mask_d       = mask_q;
    tcount_d     = tcount_q;
    pre_d        = pre_q;

    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else if (arm_ok) begin
      mode_d       = trig_mode;
      value_d      = trig_value;
      mask_d       = trig_mask;
      tcount_d     = trig_count;
      pre_d        = pre_clamped;
      ptr_d        = '0;
      din_prev_d   = '0;
      match_prev_d = 1'b0;
      cnt_d        = '0;
      done_d       = 1'b0;
      state_d      = (pre_clamped == '0) ? S_ARMED : S_PRE_FILL;
    end else if (sampling) begin
      wt_en_d      = 1'b1;
      wt_addr_d    = ptr_q;
      wt_data_d    = din;
      ptr_d        = ptr_q + ADDR_W'(1);
      din_prev_d   = din;
      match_prev_d = match;
      // The pointer starts at 0 on arm, so pre-fill and post phases end on
      // fixed addresses instead of needing separate write counters.
      case (state_q)
        S_PRE_FILL: begin
          if (ptr_q == pre_q - ADDR_W'(1)) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (fire) begin
            trig_addr_d  = ptr_q;
            start_addr_d = ptr_q - pre_q;
            state_d      = (pre_q == PRE_MAX) ? S_DONE : S_POST;
            done_d       = (pre_q == PRE_MAX);
          end else if (evt && cnt_q != '1) begin
            cnt_d = cnt_inc[TCNT_W-1:0];
          end
        end
        S_POST: begin
          if (ptr_q == start_addr_q - ADDR_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge trig_clk or negedge jrstn) begin
    if (!jrstn) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      wt_en_q      <= 1'b0;
      wt_addr_q    <= '0;
      wt_data_q    <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      done_q       <= 1'b0;
      din_prev_q   <= '0;
      match_prev_q <= 1'b0;
      cnt_q        <= '0;
      mode_q       <= '0;
      value_q      <= '0;
      mask_q       <= '0;
      tcount_q     <= '0;
      pre_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wt_en_q      <= wt_en_d;
      wt_addr_q    <= wt_addr_d;
      wt_data_q    <= wt_data_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      done_q       <= done_d;
      din_prev_q   <= din_prev_d;
      match_prev_q <= match_prev_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      value_q      <= value_d;
      mask_q       <= mask_d;
      tcount_q     <= tcount_d;
      pre_q        <= pre_d;
    end
  end

  assign wt_ce      = wt_en_q;
  assign wt_en      = wt_en_q;
  assign wt_addr    = wt_addr_q;
  assign wt_data    = wt_data_q;
  assign state      = state_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;
  assign done       = done_q;

endmodule

// File: tb/tb_cw_capture_ctrl.sv
// Self-checking bench for cw_capture_ctrl: a capture-level reference model
// compared every cycle, plus hand-computed checkpoints per scenario.
module tb_cw_capture_ctrl;
  localparam int W = 8, AW = 4, TW = 8, DEPTH = 16;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0]  din = '0;
  logic          sample_en = 1'b0, arm = 1'b0, abort = 1'b0, force_trig = 1'b0;
  logic [1:0]    trig_mode = '0;
  logic [W-1:0]  trig_value = '0, trig_mask = '0;
  logic [TW-1:0] trig_count = '0;
  logic [AW:0]   pre_len = '0;
  logic          wt_ce, wt_en, done;
  logic [AW-1:0] wt_addr, trig_addr, start_addr;
  logic [W-1:0]  wt_data;
  logic [2:0]    state;

  always #5 clk = ~clk;

  cw_capture_ctrl #(.WIDTH(W), .ADDR_W(AW), .TCNT_W(TW)) dut (
    .trig_clk(clk), .jrstn(rst_n), .din(din), .sample_en(sample_en), .arm(arm),
    .abort(abort), .force_trig(force_trig), .trig_mode(trig_mode),
    .trig_value(trig_value), .trig_mask(trig_mask), .trig_count(trig_count),
    .pre_len(pre_len), .wt_ce(wt_ce), .wt_en(wt_en), .wt_addr(wt_addr),
    .wt_data(wt_data), .state(state), .trig_addr(trig_addr),
    .start_addr(start_addr), .done(done)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases, remaining-write budgets and an event tally.
  int m_phase = 0, m_ptr = 0, m_pre = 0, m_pre_left = 0, m_post_left = 0;
  int m_events = 0, m_target = 1, m_mode = 0, m_val = 0, m_mask = 0;
  int m_prev = 0, m_prevm = 0;
  int e_en = 0, e_addr = 0, e_data = 0, e_trig = 0, e_start = 0;
  int smp, mt, evt, fire;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; e_en = 0; e_addr = 0; e_data = 0; e_trig = 0; e_start = 0;
    end else begin
      e_en = 0;
      smp = (sample_en && m_phase >= 1 && m_phase <= 3) ? 1 : 0;
      if (abort) begin
        m_phase = 0;
      end else if (arm && (m_phase == 0 || m_phase == 4)) begin
        m_pre = (int'(pre_len) > DEPTH - 1) ? DEPTH - 1 : int'(pre_len);
        m_mode = int'(trig_mode); m_val = int'(trig_value); m_mask = int'(trig_mask);
        m_target = (trig_count == 0) ? 1 : int'(trig_count);
        m_ptr = 0; m_prev = 0; m_prevm = 0; m_events = 0; m_pre_left = m_pre;
        m_phase = (m_pre == 0) ? 2 : 1;
      end else if (smp != 0) begin
        e_en = 1; e_addr = m_ptr; e_data = int'(din);
        m_ptr = (m_ptr + 1) % DEPTH;
        mt = (((int'(din) ^ m_val) & m_mask) == 0) ? 1 : 0;
        case (m_mode)
          0: evt = mt;
          1: evt = (mt != 0 && m_prevm == 0) ? 1 : 0;
          2: evt = (((int'(din) ^ m_prev) & m_mask) != 0) ? 1 : 0;
          default: evt = 0;
        endcase
        m_prev = int'(din); m_prevm = mt;
        if (m_phase == 1) begin
          m_pre_left--;
          if (m_pre_left == 0) m_phase = 2;
        end else if (m_phase == 2) begin
          fire = force_trig ? 1 : 0;
          if (fire == 0 && evt != 0) begin
            m_events++;
            fire = (m_events >= m_target) ? 1 : 0;
          end
          if (fire != 0) begin
            e_trig = e_addr;
            e_start = (e_addr - m_pre + DEPTH) % DEPTH;
            m_post_left = DEPTH - 1 - m_pre;
            m_phase = (m_post_left == 0) ? 4 : 3;
          end
        end else if (m_phase == 3) begin
          m_post_left--;
          if (m_post_left == 0) m_phase = 4;
        end
      end
    end
  end

  int n_wt = 0, last_wa = 0, last_wd = 0;
  logic [W-1:0] cap [DEPTH];

  initial forever begin
    @(negedge clk);
    check("state", int'(state), m_phase);
    check("done", int'(done), (m_phase == 4) ? 1 : 0);
    check("wt_en", int'(wt_en), e_en);
    check("wt_ce", int'(wt_ce), e_en);
    check("trig_addr", int'(trig_addr), e_trig);
    check("start_addr", int'(start_addr), e_start);
    if (e_en != 0) begin
      check("wt_addr", int'(wt_addr), e_addr);
      check("wt_data", int'(wt_data), e_data);
    end
    if (wt_en) begin
      n_wt++; last_wa = int'(wt_addr); last_wd = int'(wt_data);
      cap[wt_addr] = wt_data;
    end
  end

  int idx = 0, base = 0;

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [W-1:0] val,
                        input logic [W-1:0] mask, input logic [TW-1:0] cnt,
                        input logic [AW:0] pre);
    trig_mode = mode; trig_value = val; trig_mask = mask; trig_count = cnt; pre_len = pre;
    arm = 1'b1; sample_en = 1'b0;
    step();
    arm = 1'b0;
    base = n_wt;
  endtask

  task automatic feed_until_done(input string name, input int maxc);
    int k = 0;
    while (!done && k < maxc) begin
      din = idx[W-1:0]; sample_en = 1'b1;
      step();
      idx++; k++;
    end
    sample_en = 1'b0;
    check({name, "_reached_done"}, int'(done), 1);
    @(negedge clk); #1;
  endtask

  int v_din [9] = '{5, 7, 5, 7, 5, 7, 5, 7, 9};
  int v_en  [9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
  int f_din [8] = '{0, 1, 2, 3, 4, 'h55, 5, 6};
  int f_en  [8] = '{1, 1, 1, 1, 1, 0, 1, 1};
  int f_frc [8] = '{1, 0, 0, 0, 0, 1, 0, 1};

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_state", int'(state), 0);
    check("rst_wt_en", int'(wt_en), 0);
    check("rst_trig_addr", int'(trig_addr), 0);
    check("rst_start_addr", int'(start_addr), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    step();

    // Level trigger on 0xA5 with 4 pre-trigger samples.
    do_arm(2'b00, 8'hA5, 8'hFF, 8'd1, 5'd4);
    idx = 0;
    feed_until_done("t1", 400);
    check("t1_trig_addr", int'(trig_addr), 5);
    check("t1_start_addr", int'(start_addr), 1);
    check("t1_last_addr", last_wa, 0);
    check("t1_last_data", last_wd, 'hB0);
    check("t1_writes", n_wt - base, 177);
    for (int i = 0; i < DEPTH; i++)
      check("t1_capture", int'(cap[(1 + i) % DEPTH]), ('hA1 + i) & 'hFF);

    // Rising edge of bit0 match, third occurrence.
    do_arm(2'b01, 8'h01, 8'h01, 8'd3, 5'd1);
    idx = 0;
    feed_until_done("t2a", 100);
    check("t2a_trig_addr", int'(trig_addr), 5);
    check("t2a_start_addr", int'(start_addr), 4);
    check("t2a_last_data", last_wd, 19);
    do_arm(2'b01, 8'h01, 8'h01, 8'd3, 5'd4);
    idx = 0;
    feed_until_done("t2b", 100);
    check("t2b_trig_addr", int'(trig_addr), 9);
    check("t2b_start_addr", int'(start_addr), 5);

    // Oversized pre_len clamps to DEPTH-1: no post phase.
    do_arm(2'b00, 8'h20, 8'hFF, 8'd0, 5'd20);
    idx = 0;
    feed_until_done("t3", 100);
    check("t3_trig_addr", int'(trig_addr), 0);
    check("t3_start_addr", int'(start_addr), 1);
    check("t3_last_data", last_wd, 'h20);
    check("t3_writes", n_wt - base, 33);

    // Abort three samples into POST, then restart.
    do_arm(2'b00, 8'h08, 8'hFF, 8'd1, 5'd4);
    idx = 0;
    for (int k = 0; k < 100 && state != 3'd3; k++) begin
      din = idx[W-1:0]; sample_en = 1'b1; step(); idx++;
    end
    check("t4_in_post", int'(state), 3);
    for (int k = 0; k < 3; k++) begin
      din = idx[W-1:0]; step(); idx++;
    end
    abort = 1'b1; din = idx[W-1:0]; step(); abort = 1'b0; sample_en = 1'b0;
    check("t4_abort_state", int'(state), 0);
    check("t4_abort_wt_en", int'(wt_en), 0);
    check("t4_abort_done", int'(done), 0);
    check("t4_keep_trig", int'(trig_addr), 8);
    check("t4_keep_start", int'(start_addr), 4);
    trig_value = 8'h02; arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
    check("t4_abort_beats_arm", int'(state), 0);
    do_arm(2'b00, 8'h02, 8'hFF, 8'd1, 5'd0);
    check("t4_direct_armed", int'(state), 2);
    din = '0; sample_en = 1'b1; step();
    check("t4_restart_en", int'(wt_en), 1);
    check("t4_restart_addr", int'(wt_addr), 0);
    idx = 1;
    feed_until_done("t4", 100);
    check("t4_trig_addr", int'(trig_addr), 2);

    // Change mode measured against the previous sampled value.
    do_arm(2'b10, 8'h00, 8'hFF, 8'd2, 5'd0);
    for (int i = 0; i < 9; i++) begin
      din = v_din[i][W-1:0]; sample_en = (v_en[i] != 0); step();
    end
    sample_en = 1'b0;
    check("t5_state", int'(state), 3);
    check("t5_trig_addr", int'(trig_addr), 4);
    check("t5_start_addr", int'(start_addr), 4);
    for (int k = 0; k < 80 && !done; k++) begin
      din = k[W-1:0]; sample_en = (k % 2 == 0); step();
    end
    sample_en = 1'b0;
    check("t5_done", int'(done), 1);
    @(negedge clk); #1;
    check("t5_writes", n_wt - base, 20);

    // Manual trigger: pre-fill and unsampled pulses ignored; arm in POST ignored.
    do_arm(2'b11, 8'h00, 8'h00, 8'd1, 5'd3);
    for (int i = 0; i < 8; i++) begin
      din = f_din[i][W-1:0]; sample_en = (f_en[i] != 0); force_trig = (f_frc[i] != 0);
      step();
    end
    force_trig = 1'b0;
    check("t6_state", int'(state), 3);
    check("t6_trig_addr", int'(trig_addr), 6);
    check("t6_start_addr", int'(start_addr), 3);
    arm = 1'b1; din = 8'd7; sample_en = 1'b1; step(); arm = 1'b0;
    check("t6_arm_ignored", int'(state), 3);
    idx = 8;
    feed_until_done("t6", 100);
    check("t6_writes", n_wt - base, 19);
    check("t6_last_addr", last_wa, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "time limit");
  end

endmodule
